beam_sum_accumulator: RTL and testbench
=======================================

// Module: beam_sum_accumulator
// PURPOSE
//  Downstream stage of the delay beamformer. Consumes its output_value/data_good stream.
//  Sums NUM_TAPS qualified (delay-aligned) samples into one beam sample.
//  Scales the sum by an arithmetic right shift and saturates it to DATA_W.
//  Presents the result on a valid/ready output. Accumulates the next beam while the last result waits.
// PARAMETERS
//  DATA_W    32  width of input and output samples, signed two's complement
//  ACC_W     40  accumulator width; must satisfy ACC_W >= DATA_W + clog2(NUM_TAPS)
//  NUM_TAPS  16  qualified samples summed per beam output; legal range 1..1024
//  OUT_SHIFT 4   arithmetic right shift applied to the sum before saturation (4 = mean of 16)
// PORTS
//  clk        in   1       system clock; all logic is on the rising edge
//  rst_n      in   1       synchronous reset, active-low
//  in_value   in   DATA_W  sample from the beamformer output_value
//  in_good    in   1       sample qualifier from the beamformer data_good
//  clear      in   1       synchronous abort; discards the partial sum
//  out_sum    out  DATA_W  beam sample, signed
//  out_valid  out  1       out_sum holds an unconsumed result
//  out_ready  in   1       consumer accepts out_sum
//  out_sat    out  1       the presented result was saturated (qualifies out_sum)
//  overrun    out  1       sticky: a completed beam was dropped because the output was still held
//  tap_count  out  10      number of taps accumulated in the current beam
// BEHAVIOUR
//  Reset (rst_n=0 at edge): acc=0, tap_count=0, out_sum=0, out_valid=0, out_sat=0, overrun=0.
//  Accumulate:
//   - Each cycle with in_good=1: acc += sign_extend(in_value); tap_count increments.
//   - in_value is ignored when in_good=0.
//  Beam completion: the in_good sample that brings tap_count to NUM_TAPS.
//   - Computes r = (acc + in_value) >>> OUT_SHIFT in ACC_W bits.
//   - Clamps r to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. out_sat=1 when the clamp fires.
//   - On the next edge: acc=0 and tap_count=0. The next beam starts with no gap cycle.
//   - Latency: out_valid rises in the cycle after the completing in_good sample.
//  Output register and handshake:
//   - A transfer happens on an edge where out_valid && out_ready. out_valid drops after the transfer unless a new result loads at the same edge.
//   - While out_valid=1, out_sum and out_sat hold stable.
//   - A completion and a transfer at the same edge: the new result loads and out_valid stays 1.
//   - A completion while out_valid=1 with no transfer: the new result is dropped, the held result is kept, overrun sets to 1.
//   - overrun clears only on reset.
//  clear=1 at an edge:
//   - acc=0, tap_count=0. Any in_good sample in that cycle is discarded.
//   - The output register, out_valid and overrun are unaffected.
//   - clear overrides a completion in the same cycle; no result is produced.
//  Mid-operation reset: all state returns to reset values, and a pending result is lost.
//  NUM_TAPS=1: every in_good sample yields a result.
//  tap_count never equals NUM_TAPS after an edge.
//  The block never stalls its input; it has no input ready.
// TESTING
//  T1: reset, 16 in_good samples of 100, out_ready=1
//      -> one out_valid pulse 1 cycle after the 16th sample, out_sum=100, out_sat=0.
//  T2: samples alternate +7/-7 over 16 taps, with in_good gaps of 0-3 idle cycles
//      -> out_sum=0, tap_count visibly holds during the gaps.
//  T3: 16 samples of 0x7FFFFFFF with OUT_SHIFT=0
//      -> out_sum=0x7FFFFFFF, out_sat=1; with -2^31 -> out_sum=0x80000000, out_sat=1.
//  T4: out_ready=0 through 2 complete beams (sums 10, 20)
//      -> out_sum=10 held, overrun=1; raise out_ready -> 10 transferred, then out_valid=0.
//  T5: the 16th sample coincides with the transfer of the previous result
//      -> out_valid stays 1 and out_sum updates with no bubble.
//  T6: clear after 9 taps, then 16 samples of 5
//      -> tap_count=0 after clear, out_sum=5; rst_n=0 mid-beam -> all outputs 0.

Source files
------------

// File: rtl/beam_sum_accumulator.sv
// Beam sum accumulator: sums NUM_TAPS qualified samples per beam,
// scales by an arithmetic shift, saturates, and holds on valid/ready.
module beam_sum_accumulator #(
    parameter int DATA_W    = 32,
    parameter int ACC_W     = 40,
    parameter int NUM_TAPS  = 16,
    parameter int OUT_SHIFT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_value,
    input  logic              in_good,
    input  logic              clear,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sat,
    output logic              overrun,
    output logic [9:0]        tap_count
);

    localparam logic [9:0] LAST_TAP = 10'(NUM_TAPS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic        [9:0]       tap_q, tap_d;
    logic [DATA_W-1:0]       sum_q, sum_d;
    logic                    val_q, val_d;
    logic                    sat_q, sat_d;
    logic                    ovr_q, ovr_d;

    logic signed [ACC_W-1:0] in_ext;
    logic signed [ACC_W-1:0] total;
    logic signed [ACC_W-1:0] scaled;
    logic                    complete;
    logic                    sat_hi;
    logic                    sat_lo;
    logic                    load;
    logic                    xfer;

    assign in_ext   = ACC_W'($signed(in_value));
    assign total    = acc_q + in_ext;
    assign scaled   = total >>> OUT_SHIFT;
    assign sat_hi   = scaled > SAT_MAX;
    assign sat_lo   = scaled < SAT_MIN;
    assign complete = in_good && !clear && (tap_q == LAST_TAP);
    assign xfer     = val_q && out_ready;
    assign load     = complete && (!val_q || out_ready);

    // Accumulator and tap counter; clear wins over any sample this cycle.
    always_comb begin
        acc_d = acc_q;
        tap_d = tap_q;
        if (clear) begin
            acc_d = '0;
            tap_d = '0;
        end else if (in_good) begin
            if (complete) begin
                acc_d = '0;
                tap_d = '0;
            end else begin
                acc_d = total;
                tap_d = tap_q + 10'd1;
            end
        end
    end

    // Output register: load on completion unless a held result blocks it.
    always_comb begin
        sum_d = sum_q;
        sat_d = sat_q;
        val_d = val_q;
        ovr_d = ovr_q;
        if (xfer) begin
            val_d = 1'b0;
        end
        if (load) begin
            val_d = 1'b1;
            sat_d = sat_hi || sat_lo;
            if (sat_hi) begin
                sum_d = SAT_MAX[DATA_W-1:0];
            end else if (sat_lo) begin
                sum_d = SAT_MIN[DATA_W-1:0];
            end else begin
                sum_d = scaled[DATA_W-1:0];
            end
        end
        if (complete && val_q && !out_ready) begin
            ovr_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            tap_q <= '0;
            sum_q <= '0;
            val_q <= 1'b0;
            sat_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            tap_q <= tap_d;
            sum_q <= sum_d;
            val_q <= val_d;
            sat_q <= sat_d;
            ovr_q <= ovr_d;
        end
    end

    assign out_sum   = sum_q;
    assign out_valid = val_q;
    assign out_sat   = sat_q;
    assign overrun   = ovr_q;
    assign tap_count = tap_q;

endmodule

// File: tb/tb_beam_sum_accumulator.sv
// Scoreboard bench for beam_sum_accumulator: directed beams with
// hand-computed results, checked by independent output monitors.
module tb_beam_sum_accumulator;

    typedef struct {
        logic [31:0] sum;
        logic        sat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [31:0] in_value;
    logic        in_good;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_valid;
    logic        out_sat;
    logic        overrun;
    logic [9:0]  tap_count;

    logic [31:0] v0;
    logic        g0;
    logic        r0;
    logic [31:0] sum0;
    logic        val0;
    logic        sat0;
    logic        ovr0;
    logic [9:0]  tap0;

    exp_t q[$];
    exp_t q0[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    beam_sum_accumulator dut (
        .clk(clk), .rst_n(rst_n), .in_value(in_value),
        .in_good(in_good), .clear(clear), .out_sum(out_sum),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sat(out_sat), .overrun(overrun), .tap_count(tap_count)
    );

    beam_sum_accumulator #(.OUT_SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_value(v0),
        .in_good(g0), .clear(clear), .out_sum(sum0),
        .out_valid(val0), .out_ready(r0),
        .out_sat(sat0), .overrun(ovr0), .tap_count(tap0)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] v);
        in_value = v;
        in_good  = 1'b1;
        @(posedge clk);
        #1;
        in_good  = 1'b0;
    endtask

    task automatic send0(input logic [31:0] v);
        v0 = v;
        g0 = 1'b1;
        @(posedge clk);
        #1;
        g0 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Main monitor: every transfer must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_out: got %0h expected none", out_sum);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_sum", 64'(out_sum), 64'(e.sum));
                chk("out_sat", 64'(out_sat), 64'(e.sat));
            end
        end
    end

    // Monitor for the unshifted instance used for saturation beams.
    always @(negedge clk) begin
        if (rst_n && val0 && r0) begin
            if (q0.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_out0: got %0h expected none", sum0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("out_sum0", 64'(sum0), 64'(e.sum));
                chk("out_sat0", 64'(sat0), 64'(e.sat));
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_value  = '0;
        in_good   = 1'b0;
        out_ready = 1'b1;
        v0        = '0;
        g0        = 1'b0;
        r0        = 1'b1;
        idle(3);
        chk("rst_sum", 64'(out_sum), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_sat", 64'(out_sat), 64'd0);
        chk("rst_ovr", 64'(overrun), 64'd0);
        chk("rst_tap", 64'(tap_count), 64'd0);
        rst_n = 1'b1;
        idle(1);

        // T1: 16 x 100 -> mean 100, one cycle latency
        for (int i = 0; i < 15; i++) send(32'd100);
        chk("t1_tap15", 64'(tap_count), 64'd15);
        chk("t1_novalid", 64'(out_valid), 64'd0);
        q.push_back('{sum: 32'd100, sat: 1'b0});
        send(32'd100);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_tap0", 64'(tap_count), 64'd0);
        idle(1);
        chk("t1_drop", 64'(out_valid), 64'd0);

        // T2: +7/-7 with gaps of 0..3 idle cycles
        for (int i = 0; i < 16; i++) begin
            if (i == 15) q.push_back('{sum: 32'd0, sat: 1'b0});
            send((i % 2 == 0) ? 32'd7 : -32'sd7);
            for (int g = 0; g < i % 4; g++) begin
                idle(1);
                chk("t2_hold", 64'(tap_count), 64'((i + 1) % 16));
            end
        end
        idle(2);

        // T3: saturation on the unshifted instance
        for (int i = 0; i < 15; i++) send0(32'h7FFF_FFFF);
        q0.push_back('{sum: 32'h7FFF_FFFF, sat: 1'b1});
        send0(32'h7FFF_FFFF);
        for (int i = 0; i < 15; i++) send0(32'h8000_0000);
        q0.push_back('{sum: 32'h8000_0000, sat: 1'b1});
        send0(32'h8000_0000);
        idle(2);
        chk("t3_ovr0", 64'(ovr0), 64'd0);

        // T4: two beams while blocked -> first held, second dropped
        out_ready = 1'b0;
        q.push_back('{sum: 32'd10, sat: 1'b0});
        for (int i = 0; i < 16; i++) send(32'd10);
        chk("t4_valid", 64'(out_valid), 64'd1);
        chk("t4_ovr0", 64'(overrun), 64'd0);
        for (int i = 0; i < 16; i++) send(32'd20);
        chk("t4_held", 64'(out_sum), 64'd10);
        chk("t4_ovr1", 64'(overrun), 64'd1);
        out_ready = 1'b1;
        idle(1);
        chk("t4_empty", 64'(out_valid), 64'd0);
        chk("t4_sticky", 64'(overrun), 64'd1);

        // T5: completion coincides with transfer -> no bubble
        out_ready = 1'b0;
        q.push_back('{sum: 32'd3, sat: 1'b0});
        for (int i = 0; i < 16; i++) send(32'd3);
        for (int i = 0; i < 15; i++) send(32'd4);
        out_ready = 1'b1;
        q.push_back('{sum: 32'd4, sat: 1'b0});
        send(32'd4);
        chk("t5_valid", 64'(out_valid), 64'd1);
        chk("t5_sum", 64'(out_sum), 64'd4);
        chk("t5_ovr", 64'(overrun), 64'd1);
        idle(2);

        // T6: clear after 9 taps discards the partial sum
        for (int i = 0; i < 9; i++) send(32'd1);
        chk("t6_tap9", 64'(tap_count), 64'd9);
        clear = 1'b1;
        send(32'd1000);
        clear = 1'b0;
        chk("t6_clear", 64'(tap_count), 64'd0);
        q.push_back('{sum: 32'd5, sat: 1'b0});
        for (int i = 0; i < 16; i++) send(32'd5);
        idle(2);

        // Mid-beam reset with a pending result loses everything
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(32'd2);
        for (int i = 0; i < 5; i++) send(32'd9);
        chk("t6_pend", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        idle(1);
        chk("t6r_sum", 64'(out_sum), 64'd0);
        chk("t6r_valid", 64'(out_valid), 64'd0);
        chk("t6r_ovr", 64'(overrun), 64'd0);
        chk("t6r_tap", 64'(tap_count), 64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(3);

        chk("q_left", 64'(q.size()), 64'd0);
        chk("q0_left", 64'(q0.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
